sr_pulse_gen: RTL and testbench

Input-conditioning stage that sits directly upstream of the SR flip-flop and drives its `s`/`r` inputs. It synchronises and debounces two raw request lines (set and reset), converts each debounced rising edge into exactly one single-cycle pulse on `s` or `r`, and enforces a minimum low gap between pulses. By construction `s` and `r` are never high together, so the forbidden SR state cannot be reached.

---
 rtl/sr_pulse_gen.sv | 161 ++++++++++++++++
 tb/tb_sr_pulse_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: synchronises and debounces raw set/reset requests and turns each
// debounced rising edge into a single-cycle s or r pulse. s and r are never high together.
// Pulses are separated by a minimum low gap.
// Optional macro SR_PULSE_GEN_STATS_EN adds the drop_cnt port and its saturating merge counter.
module sr_pulse_gen #(
  parameter int unsigned DEB_CYCLES = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_in,
  input  logic       reset_in,
  output logic       s,
  output logic       r,
`ifdef SR_PULSE_GEN_STATS_EN
  output logic       busy,
  output logic [7:0] drop_cnt
`else
  output logic       busy
`endif
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Channel index 0 = set, 1 = reset
  logic [1:0]      w_raw;
  logic [1:0]      r_sync_a;
  logic [1:0]      r_sync_b;
  logic [1:0]      r_stable;
  logic [1:0][7:0] r_deb_cnt;
  logic [1:0]      r_pend;
  logic [1:0]      w_rise;
  logic [1:0]      w_consume;
  logic            w_take_r;
  logic            w_take_s;
  state_t          r_state;
  logic [7:0]      r_gap_cnt;

  assign w_raw = {reset_in, set_in};

  // A debounced 0->1 update happens on the edge the counter hits its last value
  always_comb begin
    w_rise = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_rise[i] = r_sync_b[i] && !r_stable[i] && (r_deb_cnt[i] == DEB_LAST);
    end
  end

  // Service selection from IDLE: reset channel has priority
  assign w_take_r  = (r_state == ST_IDLE) && r_pend[1];
  assign w_take_s  = (r_state == ST_IDLE) && !r_pend[1] && r_pend[0];
  assign w_consume = {w_take_r, w_take_s};

  // Two-flop synchronisers followed by the consecutive-cycle debouncers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_a  <= 2'b00;
      r_sync_b  <= 2'b00;
      r_stable  <= 2'b00;
      r_deb_cnt <= '0;
    end else begin
      r_sync_a <= w_raw;
      r_sync_b <= r_sync_a;
      for (int i = 0; i < 2; i++) begin
        if (r_sync_b[i] == r_stable[i]) begin
          r_deb_cnt[i] <= 8'd0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_stable[i]  <= r_sync_b[i];
          r_deb_cnt[i] <= 8'd0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Sticky pending flags; a new rise wins over a same-edge service
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= 2'b00;
    end else begin
      r_pend <= w_rise | (r_pend & ~w_consume);
    end
  end

  // Pulse/gap sequencer with registered s, r and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= 8'd0;
      s         <= 1'b0;
      r         <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_r || w_take_s) begin
            r_state <= ST_PULSE;
            r       <= w_take_r;
            s       <= w_take_s;
            busy    <= 1'b1;
          end
        end
        ST_PULSE: begin
          s         <= 1'b0;
          r         <= 1'b0;
          r_gap_cnt <= 8'd0;
          if (GAP_CYCLES == 0) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          s       <= 1'b0;
          r       <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SR_PULSE_GEN_STATS_EN
  logic [1:0] w_merge;
  logic [1:0] w_drop_inc;
  logic [8:0] w_drop_sum;
  logic [7:0] r_drop_cnt;

  assign w_merge    = w_rise & r_pend & ~w_consume;
  assign w_drop_inc = {1'b0, w_merge[0]} + {1'b0, w_merge[1]};
  assign w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_drop_inc);
  assign drop_cnt   = r_drop_cnt;

  // Saturating count of requests merged into an already pending one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed bench for sr_pulse_gen: default instance, a GAP_CYCLES=0 instance, and
// (with SR_PULSE_GEN_STATS_EN) a fast-debounce long-gap instance for merge counting.
module tb_sr_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_in = 1'b0, reset_in = 1'b0;
  logic s, r, busy;
  logic g0_set = 1'b0, g0_rst = 1'b0;
  logic g0_s, g0_r, g0_busy;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef SR_PULSE_GEN_STATS_EN
  logic [7:0] drop_cnt, g0_drop, st_drop;
  logic st_set = 1'b0;
  logic st_s, st_r, st_busy;

  sr_pulse_gen u_dut (.clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
                      .s(s), .r(r), .busy(busy), .drop_cnt(drop_cnt));
  sr_pulse_gen #(.DEB_CYCLES(8), .GAP_CYCLES(0)) u_g0 (.clk(clk), .rst(rst),
                      .set_in(g0_set), .reset_in(g0_rst), .s(g0_s), .r(g0_r),
                      .busy(g0_busy), .drop_cnt(g0_drop));
  sr_pulse_gen #(.DEB_CYCLES(1), .GAP_CYCLES(255)) u_st (.clk(clk), .rst(rst),
                      .set_in(st_set), .reset_in(1'b0), .s(st_s), .r(st_r),
                      .busy(st_busy), .drop_cnt(st_drop));
`else
  sr_pulse_gen u_dut (.clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
                      .s(s), .r(r), .busy(busy));
  sr_pulse_gen #(.DEB_CYCLES(8), .GAP_CYCLES(0)) u_g0 (.clk(clk), .rst(rst),
                      .set_in(g0_set), .reset_in(g0_rst), .s(g0_s), .r(g0_r),
                      .busy(g0_busy));
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 ns later, and check that s and r never overlap
  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_main_s_and_r", {7'd0, s & r}, 8'd0);
    chk("inv_g0_s_and_r", {7'd0, g0_s & g0_r}, 8'd0);
  endtask

  task automatic step_main(input string tag, input int e, input logic es, input logic er,
                           input logic eb);
    tick();
    chk($sformatf("%s_s@%0d", tag, e), {7'd0, s}, {7'd0, es});
    chk($sformatf("%s_r@%0d", tag, e), {7'd0, r}, {7'd0, er});
    chk($sformatf("%s_busy@%0d", tag, e), {7'd0, busy}, {7'd0, eb});
  endtask

  task automatic step_g0(input string tag, input int e, input logic es, input logic er,
                         input logic eb);
    tick();
    chk($sformatf("%s_s@%0d", tag, e), {7'd0, g0_s}, {7'd0, es});
    chk($sformatf("%s_r@%0d", tag, e), {7'd0, g0_r}, {7'd0, er});
    chk($sformatf("%s_busy@%0d", tag, e), {7'd0, g0_busy}, {7'd0, eb});
  endtask

  task automatic quiet(input string tag, input int n);
    for (int e = 1; e <= n; e++) step_main(tag, e, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset for two edges
    tick();
    tick();
    chk("rst_s", {7'd0, s}, 8'd0);
    chk("rst_r", {7'd0, r}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_g0_busy", {7'd0, g0_busy}, 8'd0);
`ifdef SR_PULSE_GEN_STATS_EN
    chk("rst_drop", drop_cnt, 8'd0);
    chk("rst_st_drop", st_drop, 8'd0);
`endif

    // Clean set press: s at edge 11, busy over edges 11..13
    rst = 1'b0;
    set_in = 1'b1;
    for (int e = 1; e <= 14; e++)
      step_main("press", e, e == 11, 1'b0, e >= 11 && e <= 13);

    // Falling edge produces no pulse
    set_in = 1'b0;
    quiet("fall", 20);

    // Bounce on reset_in: 5 high / 3 low never reaches 8 consecutive cycles
    for (int k = 0; k < 4; k++) begin
      reset_in = 1'b1;
      for (int e = 1; e <= 5; e++) step_main("bounce_hi", e, 1'b0, 1'b0, 1'b0);
      reset_in = 1'b0;
      for (int e = 1; e <= 3; e++) step_main("bounce_lo", e, 1'b0, 1'b0, 1'b0);
    end
    reset_in = 1'b1;
    for (int e = 1; e <= 14; e++)
      step_main("bounce_hold", e, 1'b0, e == 11, e >= 11 && e <= 13);
    reset_in = 1'b0;
    quiet("bounce_rel", 20);

    // Simultaneous requests: r at 11, s at 15
    set_in = 1'b1;
    reset_in = 1'b1;
    for (int e = 1; e <= 18; e++)
      step_main("both", e, e == 15, e == 11, (e >= 11 && e <= 13) || (e >= 15 && e <= 17));
    set_in = 1'b0;
    reset_in = 1'b0;
    quiet("both_rel", 20);

    // Reset on the cycle s is high, input held through release: re-debounced pulse
    set_in = 1'b1;
    for (int e = 1; e <= 11; e++)
      step_main("midrst_pre", e, e == 11, 1'b0, e == 11);
    rst = 1'b1;
    step_main("midrst_at", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 14; e++)
      step_main("midrst_post", e, e == 11, 1'b0, e >= 11 && e <= 13);
    set_in = 1'b0;
    quiet("midrst_rel", 20);

    // Reset while s is still pending behind an r pulse: pending s is discarded
    set_in = 1'b1;
    reset_in = 1'b1;
    for (int e = 1; e <= 11; e++)
      step_main("pendclr_pre", e, 1'b0, e == 11, e == 11);
    rst = 1'b1;
    set_in = 1'b0;
    reset_in = 1'b0;
    step_main("pendclr_at", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    quiet("pendclr_post", 20);

    // GAP_CYCLES=0 instance, staggered by one edge: r at 11, s at 13
    g0_rst = 1'b1;
    step_g0("gap0", 1, 1'b0, 1'b0, 1'b0);
    g0_set = 1'b1;
    for (int e = 2; e <= 16; e++)
      step_g0("gap0", e, e == 13, e == 11, e == 11 || e == 13);
    g0_set = 1'b0;
    g0_rst = 1'b0;
    for (int e = 1; e <= 20; e++) step_g0("gap0_rel", e, 1'b0, 1'b0, 1'b0);

`ifdef SR_PULSE_GEN_STATS_EN
    begin
      int n_s;
      // DEB_CYCLES=1: stable at edge 3, s at edge 4, then a 255-cycle gap
      st_set = 1'b1;
      for (int e = 1; e <= 4; e++) tick();
      chk("st_first_s", {7'd0, st_s}, 8'd1);
      n_s = 0;
      for (int k = 0; k < 2; k++) begin
        st_set = 1'b0;
        tick(); n_s += int'(st_s);
        tick(); n_s += int'(st_s);
        st_set = 1'b1;
        tick(); n_s += int'(st_s);
        tick(); n_s += int'(st_s);
      end
      tick(); n_s += int'(st_s);
      tick(); n_s += int'(st_s);
      chk("st_merge_pulses", 8'(n_s), 8'd0);
      chk("st_drop_one", st_drop, 8'd1);
      chk("main_drop_zero", drop_cnt, 8'd0);
      for (int k = 0; k < 1200; k++) begin
        st_set = ~st_set;
        tick();
      end
      for (int k = 0; k < 4; k++) tick();
      chk("st_drop_sat", st_drop, 8'd255);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
